// File: rtl/arb_requester.sv
// Requester side of a priority-arbitrated resource: per-port pending-job counters,
// registered request/done/overflow outputs, sticky grant-protocol error flag.
// Optional starvation monitor, enabled by defining STARVE_MON_EN.

module arb_requester_port #(
    parameter int CNT_W        = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             job_i,
    input  logic             acc_i,
    output logic             req_o,
    output logic             done_o,
    output logic             ovf_o,
`ifdef STARVE_MON_EN
    output logic             starve_o,
`endif
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             full;

    assign full = (cnt_q == CNT_MAX);

    // A job arriving alongside an accepted grant replaces the consumed one, so
    // the count holds and nothing is dropped even when saturated.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = acc_i;
        ovf_d  = job_i && !acc_i && full;
        if (job_i && !acc_i && !full)
            cnt_d = cnt_q + 1'b1;
        else if (acc_i && !job_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        req_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            req_q  <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign req_o  = req_q;
    assign done_o = done_q;
    assign ovf_o  = ovf_q;
    assign cnt_o  = cnt_q;

`ifdef STARVE_MON_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              starve_q, starve_d;

    always_comb begin
        wait_d = wait_q;
        if (!req_q || acc_i)
            wait_d = '0;
        else if (wait_q < WAIT_MAX)
            wait_d = wait_q + 1'b1;
        starve_d = starve_q || (wait_d == WAIT_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    assign starve_o = starve_q;
`endif
endmodule

module arb_requester #(
    parameter int NUM_PORTS    = 4,
    parameter int CNT_W        = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_PORTS-1:0]       job_i,
    input  logic [NUM_PORTS-1:0]       gnt_i,
    output logic [NUM_PORTS-1:0]       req_o,
    output logic [NUM_PORTS-1:0]       done_o,
    output logic [NUM_PORTS-1:0]       ovf_o,
    output logic                       err_o,
`ifdef STARVE_MON_EN
    output logic [NUM_PORTS-1:0]       starve_o,
`endif
    output logic [NUM_PORTS*CNT_W-1:0] pend_o
);
    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

    logic [NUM_PORTS-1:0]            req_w;
    logic [NUM_PORTS-1:0]            acc;
    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_w;
    logic                            multi_gnt;
    logic                            bad_gnt;
    logic                            err_q, err_d;

    // A multi-hot grant is rejected as a whole; otherwise a grant only counts
    // against a port that is actually requesting.
    always_comb begin
        multi_gnt = ((gnt_i & (gnt_i - ONE)) != '0);
        bad_gnt   = multi_gnt || ((gnt_i & ~req_w) != '0);
        acc       = multi_gnt ? '0 : (gnt_i & req_w);
        err_d     = err_q || bad_gnt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        arb_requester_port #(
            .CNT_W        (CNT_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_port (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .job_i    (job_i[p]),
            .acc_i    (acc[p]),
            .req_o    (req_w[p]),
            .done_o   (done_o[p]),
            .ovf_o    (ovf_o[p]),
`ifdef STARVE_MON_EN
            .starve_o (starve_o[p]),
`endif
            .cnt_o    (cnt_w[p])
        );
    end

    assign req_o  = req_w;
    assign err_o  = err_q;
    assign pend_o = cnt_w;
endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester: a behavioural model predicts every cycle's
// outputs, which are queued when stimulus is applied and checked after the edge.

module tb_arb_requester;
    localparam int NP  = 4;
    localparam int CW  = 3;
    localparam int SL  = 15;
    localparam int MAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    job, gnt;
    logic [NP-1:0]    req_o, done_o, ovf_o;
    logic             err_o;
    logic [NP*CW-1:0] pend_o;
`ifdef STARVE_MON_EN
    logic [NP-1:0]    starve_o;
`endif

    arb_requester #(.NUM_PORTS(NP), .CNT_W(CW), .STARVE_LIMIT(SL)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .job_i    (job),
        .gnt_i    (gnt),
        .req_o    (req_o),
        .done_o   (done_o),
        .ovf_o    (ovf_o),
        .err_o    (err_o),
`ifdef STARVE_MON_EN
        .starve_o (starve_o),
`endif
        .pend_o   (pend_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0]    req, done, ovf, starve;
        logic             err;
        logic [NP*CW-1:0] pend;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int   m_cnt[NP];
    int   m_wait[NP];
    bit   m_starve[NP];
    bit   m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, predict its outcome, then check it after the edge.
    task automatic step(input bit r, input logic [NP-1:0] j, input logic [NP-1:0] g);
        exp_t          e, o;
        logic [NP-1:0] rq, acc;
        int            ones;
        bit            bad;
        rst = r; job = j; gnt = g;
        e.done = '0; e.ovf = '0;
        if (r) begin
            for (int p = 0; p < NP; p++) begin
                m_cnt[p] = 0; m_wait[p] = 0; m_starve[p] = 0;
            end
            m_err = 0;
        end else begin
            for (int p = 0; p < NP; p++) rq[p] = (m_cnt[p] != 0);
            ones = $countones(g);
            bad  = (ones > 1) || ((g & ~rq) != '0);
            m_err = m_err || bad;
            for (int p = 0; p < NP; p++) begin
                acc[p]    = (ones == 1) && g[p] && rq[p];
                e.done[p] = acc[p];
                e.ovf[p]  = j[p] && !acc[p] && (m_cnt[p] == MAX);
                if (j[p] && !acc[p] && m_cnt[p] < MAX) m_cnt[p]++;
                else if (acc[p] && !j[p])              m_cnt[p]--;
                if (!rq[p] || acc[p]) m_wait[p] = 0;
                else if (m_wait[p] < SL) m_wait[p]++;
                if (m_wait[p] == SL) m_starve[p] = 1;
            end
        end
        for (int p = 0; p < NP; p++) begin
            e.req[p]           = (m_cnt[p] != 0);
            e.pend[p*CW +: CW] = CW'(m_cnt[p]);
            e.starve[p]        = m_starve[p];
        end
        e.err = m_err;
        sb.push_back(e);
        @(posedge clk); #1;
        o = sb.pop_front();
        chk("req",  32'(req_o),  32'(o.req));
        chk("done", 32'(done_o), 32'(o.done));
        chk("ovf",  32'(ovf_o),  32'(o.ovf));
        chk("err",  32'(err_o),  32'(o.err));
        chk("pend", 32'(pend_o), 32'(o.pend));
`ifdef STARVE_MON_EN
        chk("starve", 32'(starve_o), 32'(o.starve));
`endif
    endtask

    initial begin
        logic [NP-1:0] rq, jr, gr;
        int            k;
        rst = 1'b1; job = '0; gnt = '0;
        #1;
        step(1, '0, '0);
        step(1, '0, '0);
        chk("reset_req", 32'(req_o), 32'h0);

        // single job on port 0, granted the cycle its request is up
        step(0, 4'b0001, '0);
        chk("lat_req", 32'(req_o), 32'h1);
        step(0, '0, 4'b0001);
        chk("lat_done", 32'(done_o), 32'h1);
        step(0, '0, '0);

        // saturate port 2: eighth pulse overflows
        for (int i = 0; i < 8; i++) step(0, 4'b0100, '0);
        chk("sat_p2", 32'(pend_o[2*CW +: CW]), 32'(MAX));
        chk("sat_ovf", 32'(ovf_o), 32'h4);

        // port 1 full, job plus accepted grant together
        for (int i = 0; i < 7; i++) step(0, 4'b0010, '0);
        step(0, 4'b0010, 4'b0010);
        chk("jg_p1", 32'(pend_o[CW +: CW]), 32'(MAX));
        chk("jg_done", 32'(done_o), 32'h2);
        chk("jg_ovf", 32'(ovf_o), 32'h0);

        for (int i = 0; i < 8; i++) step(0, '0, 4'b0100);
        for (int i = 0; i < 8; i++) step(0, '0, 4'b0010);

        // protocol errors: multi-hot grant, then grant to an idle port
        step(1, '0, '0);
        step(0, 4'b0011, '0);
        step(0, '0, 4'b0011);
        chk("err_multi", 32'(err_o), 32'h1);
        step(0, '0, 4'b0100);
        for (int i = 0; i < 3; i++) step(0, '0, '0);
        chk("err_sticky", 32'(err_o), 32'h1);

        // load counts 3,5,0,7 then reset with all jobs pulsing
        step(1, '0, '0);
        for (int i = 0; i < 7; i++)
            step(0, {1'b1, 1'b0, (i < 5) ? 1'b1 : 1'b0, (i < 3) ? 1'b1 : 1'b0}, '0);
        step(1, 4'b1111, 4'b1111);
        chk("rst_pend", 32'(pend_o), 32'h0);
        step(0, '0, '0);

        // port 3 held off while port 0 is granted every cycle
        step(0, 4'b1001, '0);
        for (int i = 0; i < 20; i++) step(0, 4'b0001, 4'b0001);
        step(1, '0, '0);

        // random jobs with arbitrator-style single grants to requesting ports
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < NP; p++) rq[p] = (m_cnt[p] != 0);
            jr = NP'($urandom_range(0, 15)) & NP'($urandom_range(0, 15));
            gr = '0;
            if (rq != '0 && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, NP - 1);
                while (!rq[k]) k = (k + 1) % NP;
                gr[k] = 1'b1;
            end
            step(0, jr, gr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
